// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
//
// Circular return-address stack that feeds the return-target prediction to the
// branch history table. Calls resolved in EX push their link address and
// returns resolved in EX pop it. The top entry is always presented on
// RETURN_ADDR, and consumers qualify it with RAS_VALID. When the stack is full,
// a push overwrites the oldest entry: the pointer wraps, so the newest calls
// keep predicting correctly.
//
// Ports
//   CLK               in   system clock, rising edge
//   RSTN              in   asynchronous active-low reset
//   CACHE_READY       in   I-cache ready (update qualifier)
//   CACHE_READY_DATA  in   D-cache ready (update qualifier)
//   FLUSH             in   EX instruction squashed; blocks PUSH/POP but not CLEAR
//   CLEAR             in   synchronous empty; wins over PUSH/POP
//   PUSH              in   EX instruction is a call
//   POP               in   EX instruction is a return
//   PUSH_ADDR         in   link address to push (bits [1:0] ignored)
//   RETURN_ADDR       out  predicted return target, {top entry, 2'b00}
//   RAS_VALID         out  stack holds at least one entry
//   RAS_COUNT         out  occupancy, 0..STACK_DEPTH
//   OVERFLOW          out  1-cycle pulse: a push overwrote the oldest entry
//   UNDERFLOW         out  1-cycle pulse: a pop was attempted on an empty stack
// -----------------------------------------------------------------------------
module return_addr_stack #(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int STACK_DEPTH = 8,
    localparam int PTR_WIDTH   = $clog2(STACK_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CACHE_READY,
    input  logic                  CACHE_READY_DATA,
    input  logic                  FLUSH,
    input  logic                  CLEAR,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic [ADDR_WIDTH-1:0] PUSH_ADDR,
    output logic [ADDR_WIDTH-1:0] RETURN_ADDR,
    output logic                  RAS_VALID,
    output logic [PTR_WIDTH:0]    RAS_COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int ENTRY_WIDTH = ADDR_WIDTH - 2;

    localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(STACK_DEPTH);
    localparam logic [PTR_WIDTH:0]   ONE_COUNT  = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH-1:0] ONE_PTR    = PTR_WIDTH'(1);

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_SWAP   // push and pop together: replace the top entry in place
    } op_e;

    // Entries hold word addresses only; the two low bits are always zero.
    logic [ENTRY_WIDTH-1:0] mem [STACK_DEPTH];

    logic [PTR_WIDTH-1:0]   tos_ptr, tos_ptr_nxt;
    logic [PTR_WIDTH:0]     count, count_nxt;
    logic                   overflow_q, overflow_nxt;
    logic                   underflow_q, underflow_nxt;

    logic                   wr_en;
    logic [PTR_WIDTH-1:0]   wr_idx;
    logic [ENTRY_WIDTH-1:0] wr_data;

    logic                   cache_ready;
    logic                   upd_en;
    op_e                    op;

    // Byte-offset bits of the link address carry no information.
    logic                   unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, PUSH_ADDR[1:0]};

    // CLEAR ignores FLUSH: a fence.i or context switch must empty the stack
    // even when the instruction in EX is being squashed.
    assign cache_ready = CACHE_READY & CACHE_READY_DATA;
    assign upd_en      = cache_ready & ~FLUSH;

    always_comb begin
        unique case ({PUSH, POP})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_SWAP;
            default: op = OP_NONE;
        endcase
    end

    // NOTE: every signal gets a default before the branches, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        tos_ptr_nxt   = tos_ptr;
        count_nxt     = count;
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = tos_ptr;
        wr_data       = PUSH_ADDR[ADDR_WIDTH-1:2];

        if (cache_ready && CLEAR) begin
            // Only the occupancy is dropped; pointer and entries are kept.
            count_nxt = '0;
        end else if (upd_en) begin
            unique case (op)
                OP_PUSH: begin
                    tos_ptr_nxt = tos_ptr + ONE_PTR;
                    wr_en       = 1'b1;
                    wr_idx      = tos_ptr + ONE_PTR;
                    if (count == FULL_COUNT) begin
                        // The incremented pointer lands on the oldest entry.
                        overflow_nxt = 1'b1;
                    end else begin
                        count_nxt = count + ONE_COUNT;
                    end
                end
                OP_POP: begin
                    if (count == '0) begin
                        underflow_nxt = 1'b1;
                    end else begin
                        tos_ptr_nxt = tos_ptr - ONE_PTR;
                        count_nxt   = count - ONE_COUNT;
                    end
                end
                OP_SWAP: begin
                    wr_en = 1'b1;
                    if (count == '0) begin
                        count_nxt = ONE_COUNT;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tos_ptr     <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_ptr     <= tos_ptr_nxt;
            count       <= count_nxt;
            overflow_q  <= overflow_nxt;
            underflow_q <= underflow_nxt;
        end
    end

    // NOTE: the entries are reset because RETURN_ADDR is visible even on an
    // empty stack and must read as zero after reset; with eight entries this
    // is a register file, not a RAM macro, so the reset costs nothing unusual.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // No forwarding: a push becomes visible on RETURN_ADDR the cycle after it.
    assign RETURN_ADDR = {mem[tos_ptr], 2'b00};
    assign RAS_VALID   = (count != '0);
    assign RAS_COUNT   = count;
    assign OVERFLOW    = overflow_q;
    assign UNDERFLOW   = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// -----------------------------------------------------------------------------
// tb_return_addr_stack
//
// Directed bench for return_addr_stack (ADDR_WIDTH=32, STACK_DEPTH=8).
// Each scenario task drives one-cycle operations and compares the outputs
// #1 after the rising edge against hand-computed values.
// -----------------------------------------------------------------------------
module tb_return_addr_stack;

    logic        CLK;
    logic        RSTN;
    logic        CACHE_READY;
    logic        CACHE_READY_DATA;
    logic        FLUSH;
    logic        CLEAR;
    logic        PUSH;
    logic        POP;
    logic [31:0] PUSH_ADDR;
    logic [31:0] RETURN_ADDR;
    logic        RAS_VALID;
    logic [3:0]  RAS_COUNT;
    logic        OVERFLOW;
    logic        UNDERFLOW;

    int n_checks;
    int n_fail;

    return_addr_stack #(
        .ADDR_WIDTH (32),
        .STACK_DEPTH(8)
    ) dut (
        .CLK             (CLK),
        .RSTN            (RSTN),
        .CACHE_READY     (CACHE_READY),
        .CACHE_READY_DATA(CACHE_READY_DATA),
        .FLUSH           (FLUSH),
        .CLEAR           (CLEAR),
        .PUSH            (PUSH),
        .POP             (POP),
        .PUSH_ADDR       (PUSH_ADDR),
        .RETURN_ADDR     (RETURN_ADDR),
        .RAS_VALID       (RAS_VALID),
        .RAS_COUNT       (RAS_COUNT),
        .OVERFLOW        (OVERFLOW),
        .UNDERFLOW       (UNDERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Return all control inputs to their quiet, ready state.
    task automatic idle_inputs();
        CACHE_READY      = 1'b1;
        CACHE_READY_DATA = 1'b1;
        FLUSH            = 1'b0;
        CLEAR            = 1'b0;
        PUSH             = 1'b0;
        POP              = 1'b0;
        PUSH_ADDR        = 32'h0;
    endtask

    // Present one cycle of stimulus, clock it, and leave outputs ready to sample.
    task automatic op_cycle(input logic push, input logic pop, input logic [31:0] addr,
                            input logic cr, input logic crd, input logic flush,
                            input logic clear);
        PUSH             = push;
        POP              = pop;
        PUSH_ADDR        = addr;
        CACHE_READY      = cr;
        CACHE_READY_DATA = crd;
        FLUSH            = flush;
        CLEAR            = clear;
        @(posedge CLK);
        #1;
        idle_inputs();
    endtask

    task automatic do_push(input logic [31:0] addr);
        op_cycle(1'b1, 1'b0, addr, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_pop();
        op_cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_idle();
        op_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        idle_inputs();
        RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (RETURN_ADDR !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_return_addr: got %h want %h", RETURN_ADDR, 32'h0);
        end
        n_checks++;
        if (RAS_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", RAS_VALID);
        end
        n_checks++;
        if (RAS_COUNT !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", RAS_COUNT);
        end
        n_checks++;
        if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_pulses: got ovf=%b unf=%b want 0 0", OVERFLOW, UNDERFLOW);
        end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        do_push(32'h0000_0A00);
        do_push(32'h0000_0B00);
        do_push(32'h0000_0C00);
        n_checks++;
        if (RAS_COUNT !== 4'd3) begin
            n_fail++;
            $display("FAIL midreset_pre_count: got %0d want 3", RAS_COUNT);
        end
        // Assert reset while a push is still being offered; reset must dominate.
        RSTN = 1'b0;
        PUSH = 1'b1;
        PUSH_ADDR = 32'h0000_0D00;
        @(posedge CLK);
        #1;
        n_checks++;
        if (RAS_COUNT !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d want 0", RAS_COUNT);
        end
        n_checks++;
        if (RAS_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_valid: got %b want 0", RAS_VALID);
        end
        n_checks++;
        if (RETURN_ADDR !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_return_addr: got %h want %h", RETURN_ADDR, 32'h0);
        end
        idle_inputs();
        RSTN = 1'b1;
    endtask

    task automatic test_push_pop();
        apply_reset();
        do_push(32'h0000_0100);
        n_checks++;
        if (RETURN_ADDR !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL push1_return_addr: got %h want %h", RETURN_ADDR, 32'h100);
        end
        n_checks++;
        if (RAS_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL push1_valid: got %b want 1", RAS_VALID);
        end
        do_push(32'h0000_0200);
        n_checks++;
        if (RETURN_ADDR !== 32'h0000_0200 || RAS_COUNT !== 4'd2) begin
            n_fail++;
            $display("FAIL push2: got addr=%h count=%0d want addr=%h count=2",
                     RETURN_ADDR, RAS_COUNT, 32'h200);
        end
        do_pop();
        n_checks++;
        if (RETURN_ADDR !== 32'h0000_0100 || RAS_COUNT !== 4'd1) begin
            n_fail++;
            $display("FAIL pop1: got addr=%h count=%0d want addr=%h count=1",
                     RETURN_ADDR, RAS_COUNT, 32'h100);
        end
        do_pop();
        n_checks++;
        if (RAS_COUNT !== 4'd0 || RAS_VALID !== 1'b0 || UNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_to_empty: got count=%0d valid=%b unf=%b want 0 0 0",
                     RAS_COUNT, RAS_VALID, UNDERFLOW);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_addr;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            do_push(32'h0000_1000 + 32'(4 * k));
            n_checks++;
            if (OVERFLOW !== (k == 8)) begin
                n_fail++;
                $display("FAIL ovf_pulse_push%0d: got %b want %b", k, OVERFLOW, (k == 8));
            end
            n_checks++;
            if (RAS_COUNT !== ((k < 8) ? 4'(k + 1) : 4'd8)) begin
                n_fail++;
                $display("FAIL ovf_count_push%0d: got %0d want %0d", k, RAS_COUNT,
                         (k < 8) ? k + 1 : 8);
            end
        end
        // Before pop j the top is 0x1020 - 4j; the overwritten 0x1000 never appears.
        for (int j = 0; j < 8; j++) begin
            exp_addr = 32'h0000_1020 - 32'(4 * j);
            n_checks++;
            if (RETURN_ADDR !== exp_addr) begin
                n_fail++;
                $display("FAIL ovf_pop%0d_return_addr: got %h want %h", j, RETURN_ADDR, exp_addr);
            end
            do_pop();
            n_checks++;
            if (RAS_COUNT !== 4'(7 - j) || OVERFLOW !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_pop%0d_state: got count=%0d ovf=%b want count=%0d ovf=0",
                         j, RAS_COUNT, OVERFLOW, 7 - j);
            end
        end
        do_pop();
        n_checks++;
        if (UNDERFLOW !== 1'b1 || RAS_COUNT !== 4'd0) begin
            n_fail++;
            $display("FAIL underflow_pulse: got unf=%b count=%0d want unf=1 count=0",
                     UNDERFLOW, RAS_COUNT);
        end
        do_idle();
        n_checks++;
        if (UNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_one_cycle: got %b want 0", UNDERFLOW);
        end
    endtask

    task automatic test_stall_flush();
        apply_reset();
        do_push(32'h0000_0100);
        op_cycle(1'b1, 1'b0, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (RAS_COUNT !== 4'd1 || RETURN_ADDR !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL stall_push: got count=%0d addr=%h want count=1 addr=%h",
                     RAS_COUNT, RETURN_ADDR, 32'h100);
        end
        op_cycle(1'b1, 1'b0, 32'h0000_0400, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (RAS_COUNT !== 4'd1 || RETURN_ADDR !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL flush_push: got count=%0d addr=%h want count=1 addr=%h",
                     RAS_COUNT, RETURN_ADDR, 32'h100);
        end
        // A stalled pop must not pop.
        op_cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (RAS_COUNT !== 4'd1) begin
            n_fail++;
            $display("FAIL stall_pop: got count=%0d want 1", RAS_COUNT);
        end
        // A squashed pop on an empty stack must not raise UNDERFLOW.
        do_pop();
        op_cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (UNDERFLOW !== 1'b0 || RAS_COUNT !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_pop_empty: got unf=%b count=%0d want unf=0 count=0",
                     UNDERFLOW, RAS_COUNT);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        do_push(32'h0000_0100);
        do_push(32'h0000_0200);
        op_cycle(1'b1, 1'b1, 32'h0000_0500, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (RETURN_ADDR !== 32'h0000_0500 || RAS_COUNT !== 4'd2) begin
            n_fail++;
            $display("FAIL swap_count2: got addr=%h count=%0d want addr=%h count=2",
                     RETURN_ADDR, RAS_COUNT, 32'h500);
        end
        n_checks++;
        if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin
            n_fail++;
            $display("FAIL swap_pulses: got ovf=%b unf=%b want 0 0", OVERFLOW, UNDERFLOW);
        end
        do_pop();
        n_checks++;
        if (RETURN_ADDR !== 32'h0000_0100 || RAS_COUNT !== 4'd1) begin
            n_fail++;
            $display("FAIL swap_then_pop: got addr=%h count=%0d want addr=%h count=1",
                     RETURN_ADDR, RAS_COUNT, 32'h100);
        end
        // Empty stack; low address bits set to show they are dropped.
        apply_reset();
        op_cycle(1'b1, 1'b1, 32'h0000_0503, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (RETURN_ADDR !== 32'h0000_0500 || RAS_COUNT !== 4'd1 || UNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_empty: got addr=%h count=%0d unf=%b want addr=%h count=1 unf=0",
                     RETURN_ADDR, RAS_COUNT, UNDERFLOW, 32'h500);
        end
    endtask

    task automatic test_clear();
        apply_reset();
        for (int k = 1; k <= 5; k++) begin
            do_push(32'(k * 32'h10));
        end
        n_checks++;
        if (RAS_COUNT !== 4'd5) begin
            n_fail++;
            $display("FAIL clear_pre_count: got %0d want 5", RAS_COUNT);
        end
        op_cycle(1'b1, 1'b0, 32'h0000_0600, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (RAS_COUNT !== 4'd0 || RAS_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_push: got count=%0d valid=%b want 0 0", RAS_COUNT, RAS_VALID);
        end
        // Pointer and entries are untouched, so the stale top is still 0x50.
        n_checks++;
        if (RETURN_ADDR !== 32'h0000_0050) begin
            n_fail++;
            $display("FAIL clear_push_discarded: got %h want %h", RETURN_ADDR, 32'h50);
        end
        // CLEAR ignores FLUSH but honours the cache-ready stall.
        do_push(32'h0000_0700);
        op_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (RAS_COUNT !== 4'd1) begin
            n_fail++;
            $display("FAIL clear_stalled: got count=%0d want 1", RAS_COUNT);
        end
        op_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (RAS_COUNT !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_with_flush: got count=%0d want 0", RAS_COUNT);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RSTN     = 1'b0;
        idle_inputs();

        test_reset();
        test_reset_mid_op();
        test_push_pop();
        test_overflow();
        test_stall_flush();
        test_simultaneous();
        test_clear();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
